// File: rtl/render_cmd_sequencer.sv
// render_cmd_sequencer: buffers one host draw-command packet, replays it into
// the render unit with the STATUS/VALID byte protocol, then holds RU_ENB
// until the render unit reports that drawing is finished.
// Optional build macro RENDER_SEQ_PKT_COUNT_EN adds the PKT_COUNT output.
module render_cmd_sequencer #(
  parameter int unsigned GAP        = 3,
  parameter int unsigned TMO_CYCLES = 65535
) (
  input  logic       ACLK,
  input  logic       RESET,
  input  logic [7:0] IN_BYTE,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       RU_STATUS,
  output logic [7:0] RU_BYTE,
  output logic       RU_VALID,
  output logic       RU_ENB,
  input  logic       RU_FINISH_READ,
  input  logic       RU_FINISH_WRITE,
  output logic       BUSY,
  output logic       ERR_HDR,
  output logic       TIMEOUT
`ifdef RENDER_SEQ_PKT_COUNT_EN
  ,
  output logic [15:0] PKT_COUNT
`endif
);

  localparam logic [3:0]  GAP_C    = 4'(GAP);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_START,
    S_DRIVE,
    S_WAIT_READ,
    S_WAIT_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;        // buffer index, never wraps past last_q
  logic [2:0]  last_q, last_d;      // L-1, index of the final packet byte
  logic [3:0]  slot_q, slot_d;      // position inside one DRIVE byte slot
  logic [15:0] tmr_q, tmr_d;        // wait-state timer

  logic        in_ready_q, in_ready_d;
  logic        ru_status_q, ru_status_d;
  logic [7:0]  ru_byte_q, ru_byte_d;
  logic        ru_valid_q, ru_valid_d;
  logic        ru_enb_q, ru_enb_d;
  logic        busy_q, busy_d;
  logic        err_hdr_q, err_hdr_d;
  logic        timeout_q, timeout_d;

  logic [7:0]  pkt_mem [8];
  logic        mem_we;
  logic        xfer;

  assign xfer = IN_VALID && in_ready_q;

`ifdef RENDER_SEQ_PKT_COUNT_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        pkt_done;
`endif

  // Next-state, counters and registered-output values.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    slot_d    = slot_q;
    tmr_d     = tmr_q;
    err_hdr_d = 1'b0;
    timeout_d = 1'b0;
    mem_we    = 1'b0;
`ifdef RENDER_SEQ_PKT_COUNT_EN
    pkt_done  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (IN_BYTE == 8'h00) begin
            err_hdr_d = 1'b1;
          end else begin
            mem_we  = 1'b1;                    // idx_q is 0 in IDLE
            last_d  = {IN_BYTE[1:0], 1'b1};    // L-1 = 2*H[1:0]+1
            idx_d   = 3'd1;
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          mem_we = 1'b1;
          if (idx_q == last_q) state_d = S_START;
          else                 idx_d   = idx_q + 3'd1;
        end
      end
      S_START: begin
        idx_d   = 3'd0;
        slot_d  = 4'd0;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (slot_q == GAP_C) begin
          slot_d = 4'd0;
          if (idx_q == last_q) begin
            idx_d   = 3'd0;
            tmr_d   = 16'd0;
            state_d = S_WAIT_READ;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      S_WAIT_READ: begin
        // Finish has priority over an expiring timer.
        if (RU_FINISH_READ) begin
          tmr_d   = 16'd0;
          state_d = S_WAIT_WRITE;
        end else if (tmr_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_WAIT_WRITE: begin
        if (RU_FINISH_WRITE) begin
          state_d  = S_IDLE;
`ifdef RENDER_SEQ_PKT_COUNT_EN
          pkt_done = 1'b1;
`endif
        end else if (tmr_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake, status, enable and busy follow the state being entered.
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_COLLECT);
    ru_status_d = (state_d == S_START);
    ru_enb_d    = (state_d == S_WAIT_WRITE);
    busy_d      = (state_d != S_IDLE);
    // Byte lane trails the DRIVE state by one cycle, which places the first
    // RU_VALID two cycles after RU_STATUS.
    ru_valid_d  = (state_q == S_DRIVE) && (slot_q == 4'd0);
    ru_byte_d   = (state_q == S_DRIVE) ? pkt_mem[idx_q] : ru_byte_q;

`ifdef RENDER_SEQ_PKT_COUNT_EN
    pkt_count_d = pkt_done ? pkt_count_q + 16'd1 : pkt_count_q;
`endif
  end

  // State, counters and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      last_q      <= 3'd0;
      slot_q      <= 4'd0;
      tmr_q       <= 16'd0;
      in_ready_q  <= 1'b0;
      ru_status_q <= 1'b0;
      ru_byte_q   <= 8'h00;
      ru_valid_q  <= 1'b0;
      ru_enb_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_hdr_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef RENDER_SEQ_PKT_COUNT_EN
      pkt_count_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      slot_q      <= slot_d;
      tmr_q       <= tmr_d;
      in_ready_q  <= in_ready_d;
      ru_status_q <= ru_status_d;
      ru_byte_q   <= ru_byte_d;
      ru_valid_q  <= ru_valid_d;
      ru_enb_q    <= ru_enb_d;
      busy_q      <= busy_d;
      err_hdr_q   <= err_hdr_d;
      timeout_q   <= timeout_d;
`ifdef RENDER_SEQ_PKT_COUNT_EN
      pkt_count_q <= pkt_count_d;
`endif
    end
  end

  // Packet buffer write port.
  // NOTE: the buffer has no reset; every byte is written before it is ever read.
  always_ff @(posedge ACLK) begin
    if (mem_we) pkt_mem[idx_q] <= IN_BYTE;
  end

  assign IN_READY  = in_ready_q;
  assign RU_STATUS = ru_status_q;
  assign RU_BYTE   = ru_byte_q;
  assign RU_VALID  = ru_valid_q;
  assign RU_ENB    = ru_enb_q;
  assign BUSY      = busy_q;
  assign ERR_HDR   = err_hdr_q;
  assign TIMEOUT   = timeout_q;
`ifdef RENDER_SEQ_PKT_COUNT_EN
  assign PKT_COUNT = pkt_count_q;
`endif

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Directed bench for render_cmd_sequencer: a per-cycle vector table for the
// basic 4-byte packet, then hand sequences for the 8-byte enable window,
// dropped header, reset during replay, and timeouts. A second instance with
// TMO_CYCLES=16 shares the inputs and is checked only in the timeout sequence.
module tb_render_cmd_sequencer;

  logic       ACLK = 1'b0;
  logic       RESET;
  logic [7:0] IN_BYTE;
  logic       IN_VALID;
  logic       RU_FINISH_READ;
  logic       RU_FINISH_WRITE;

  logic       IN_READY, RU_STATUS, RU_VALID, RU_ENB, BUSY, ERR_HDR, TIMEOUT;
  logic [7:0] RU_BYTE;
  logic       t_in_ready, t_ru_status, t_ru_valid, t_ru_enb, t_busy, t_err_hdr, t_timeout;
  logic [7:0] t_ru_byte;
`ifdef RENDER_SEQ_PKT_COUNT_EN
  logic [15:0] PKT_COUNT, t_pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  render_cmd_sequencer #(.GAP(3), .TMO_CYCLES(40)) dut (
    .ACLK(ACLK), .RESET(RESET), .IN_BYTE(IN_BYTE), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .RU_STATUS(RU_STATUS), .RU_BYTE(RU_BYTE),
    .RU_VALID(RU_VALID), .RU_ENB(RU_ENB), .RU_FINISH_READ(RU_FINISH_READ),
    .RU_FINISH_WRITE(RU_FINISH_WRITE), .BUSY(BUSY), .ERR_HDR(ERR_HDR),
    .TIMEOUT(TIMEOUT)
`ifdef RENDER_SEQ_PKT_COUNT_EN
    , .PKT_COUNT(PKT_COUNT)
`endif
  );

  render_cmd_sequencer #(.GAP(3), .TMO_CYCLES(16)) dut_t (
    .ACLK(ACLK), .RESET(RESET), .IN_BYTE(IN_BYTE), .IN_VALID(IN_VALID),
    .IN_READY(t_in_ready), .RU_STATUS(t_ru_status), .RU_BYTE(t_ru_byte),
    .RU_VALID(t_ru_valid), .RU_ENB(t_ru_enb), .RU_FINISH_READ(RU_FINISH_READ),
    .RU_FINISH_WRITE(RU_FINISH_WRITE), .BUSY(t_busy), .ERR_HDR(t_err_hdr),
    .TIMEOUT(t_timeout)
`ifdef RENDER_SEQ_PKT_COUNT_EN
    , .PKT_COUNT(t_pkt_count)
`endif
  );

  // Outputs packed as {rdy, status, valid, enb, busy, err, tmo, byte}.
  typedef struct {
    logic [7:0]  ib;
    logic        iv;
    logic        fr;
    logic        fw;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs [28];

  function automatic logic [14:0] outs_now();
    return {IN_READY, RU_STATUS, RU_VALID, RU_ENB, BUSY, ERR_HDR, TIMEOUT, RU_BYTE};
  endfunction

  function automatic vec_t mkv(input logic [7:0] ib, input logic iv, input logic fr,
                               input logic fw, input logic [6:0] flags, input logic [7:0] b);
    vec_t v;
    v.ib = ib; v.iv = iv; v.fr = fr; v.fw = fw; v.exp = {flags, b};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Offer one byte, holding IN_VALID until it transfers (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int t;
    IN_BYTE  = b;
    IN_VALID = 1'b1;
    t = 0;
    do begin
      rdy = IN_READY;
      cycle();
      t++;
    end while (!rdy && t < 50);
    if (!rdy) check("send_byte handshake", 32'(rdy), 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] p [8], input int n);
    for (int i = 0; i < n; i++) send_byte(p[i]);
    IN_VALID = 1'b0;
  endtask

  // Expect RU_STATUS now or soon, then n RU_VALID pulses at cycles 2,6,10,...
  task automatic replay_check(input string tag, input logic [7:0] p [8], input int n);
    int t, cyc, k;
    t = 0;
    while (RU_STATUS !== 1'b1 && t < 40) begin cycle(); t++; end
    check({tag, " status"}, 32'(RU_STATUS), 32'd1);
    cyc = 0;
    k = 0;
    while (k < n && cyc < 60) begin
      cycle();
      cyc++;
      if (RU_VALID) begin
        check($sformatf("%s slot%0d {cycle,byte}", tag, k),
              {16'(cyc), 8'h00, RU_BYTE}, {16'(2 + 4 * k), 8'h00, p[k]});
        k++;
      end
    end
    check({tag, " pulse count"}, 32'(k), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pkt [8];
    logic [7:0] four [4];
    int enb_cnt, t_main, t_t, n_t, enb_hi;

    RESET = 1'b1; IN_BYTE = 8'h00; IN_VALID = 1'b0;
    RU_FINISH_READ = 1'b0; RU_FINISH_WRITE = 1'b0;
    repeat (3) cycle();
    check("reset outputs", 32'(outs_now()), 32'd0);

    // ---- Vector table: header 0x01 (L=4), IN_VALID held high ----
    four = '{8'h01, 8'h10, 8'h22, 8'h33};
    //                   ib     iv fr fw  rdy st vl en bs er to  byte
    vecs[0] = mkv(8'h00, 0, 0, 0, 7'b1000000, 8'h00);
    vecs[1] = mkv(8'h01, 1, 0, 0, 7'b1000100, 8'h00);
    vecs[2] = mkv(8'h10, 1, 0, 0, 7'b1000100, 8'h00);
    vecs[3] = mkv(8'h22, 1, 0, 0, 7'b1000100, 8'h00);
    vecs[4] = mkv(8'h33, 1, 0, 0, 7'b0100100, 8'h00);
    vecs[5] = mkv(8'h44, 1, 0, 0, 7'b0000100, 8'h00);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++)
        vecs[6 + 4 * s + c] = mkv(8'h44, 1, 0, 0, (c == 0) ? 7'b0010100 : 7'b0000100, four[s]);
    vecs[22] = mkv(8'h00, 0, 0, 0, 7'b0000100, 8'h33);
    vecs[23] = mkv(8'h00, 0, 1, 1, 7'b0001100, 8'h33);
    vecs[24] = mkv(8'h00, 0, 0, 0, 7'b0001100, 8'h33);
    vecs[25] = mkv(8'h00, 0, 0, 0, 7'b0001100, 8'h33);
    vecs[26] = mkv(8'h00, 0, 0, 1, 7'b1000000, 8'h33);
    vecs[27] = mkv(8'h00, 0, 0, 0, 7'b1000000, 8'h33);

    RESET = 1'b0;
    for (int i = 0; i < 28; i++) begin
      IN_BYTE = vecs[i].ib; IN_VALID = vecs[i].iv;
      RU_FINISH_READ = vecs[i].fr; RU_FINISH_WRITE = vecs[i].fw;
      cycle();
      check($sformatf("vec%0d outputs", i), 32'(outs_now()), 32'(vecs[i].exp));
    end
    IN_VALID = 1'b0; RU_FINISH_READ = 1'b0; RU_FINISH_WRITE = 1'b0;
`ifdef RENDER_SEQ_PKT_COUNT_EN
    check("pkt_count after first packet", 32'(PKT_COUNT), 32'd1);
`endif

    // ---- 8-byte packet, RU_ENB window of exactly 20 cycles ----
    pkt = '{8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_pkt(pkt, 8);
    replay_check("L8", pkt, 8);
    repeat (3) cycle();
    check("L8 enb before finish_read", {31'd0, RU_ENB}, 32'd0);
    check("L8 busy in wait_read", {31'd0, BUSY}, 32'd1);
    RU_FINISH_READ = 1'b1;
    cycle();
    RU_FINISH_READ = 1'b0;
    enb_cnt = RU_ENB ? 1 : 0;
    for (int i = 1; i <= 25; i++) begin
      RU_FINISH_WRITE = (i == 20);
      cycle();
      if (RU_ENB) enb_cnt++;
    end
    RU_FINISH_WRITE = 1'b0;
    check("L8 enb high cycles", 32'(enb_cnt), 32'd20);
    check("L8 busy after finish", {31'd0, BUSY}, 32'd0);
`ifdef RENDER_SEQ_PKT_COUNT_EN
    check("pkt_count after second packet", 32'(PKT_COUNT), 32'd2);
`endif

    // ---- Dropped 0x00 header, then a 6-byte packet cut by reset ----
    send_byte(8'h00);
    check("err_hdr pulse", {30'd0, ERR_HDR, BUSY}, {30'd0, 1'b1, 1'b0});
    send_byte(8'h02);
    check("err_hdr single cycle, busy", {30'd0, ERR_HDR, BUSY}, {30'd0, 1'b0, 1'b1});
    pkt = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00};
    for (int i = 1; i < 6; i++) send_byte(pkt[i]);
    IN_VALID = 1'b0;
    replay_check("L6", pkt, 2);
    RESET = 1'b1;
    #1;
    check("async reset outputs", 32'(outs_now()), 32'd0);
`ifdef RENDER_SEQ_PKT_COUNT_EN
    check("pkt_count after reset", 32'(PKT_COUNT), 32'd0);
`endif
    @(negedge ACLK);
    RESET = 1'b0;

    // ---- 2-byte packet after reset, then timeouts at 16 and 40 cycles ----
    pkt = '{8'h04, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 2);
    replay_check("L2", pkt, 2);
    t_main = -1; t_t = -1; n_t = 0; enb_hi = 0;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      if (t_timeout) begin n_t++; if (t_t < 0) t_t = c; end
      if (TIMEOUT && t_main < 0) t_main = c;
      if (RU_ENB || t_ru_enb) enb_hi++;
    end
    check("tmo16 timeout cycle", 32'(t_t), 32'd19);
    check("tmo16 timeout pulse width", 32'(n_t), 32'd1);
    check("tmo40 timeout cycle", 32'(t_main), 32'd43);
    check("timeout enb never high", 32'(enb_hi), 32'd0);
    check("after timeout rdy/busy", {30'd0, IN_READY, BUSY}, {30'd0, 1'b1, 1'b0});
    check("tmo16 after timeout rdy/busy", {30'd0, t_in_ready, t_busy}, {30'd0, 1'b1, 1'b0});
`ifdef RENDER_SEQ_PKT_COUNT_EN
    check("pkt_count unchanged by timeout", 32'(PKT_COUNT), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
